// File: rtl/fsmc_pkg.sv
// Shared types and constants for the multiplexed-bus (NADV/NWE/NOE/AD) initiator.
package fsmc_pkg;

  localparam int AD_W_DEF   = 18;
  localparam int DATA_W_DEF = 16;
  localparam int CNT_W      = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    AHOLD = 3'd2,
    WDATA = 3'd3,
    WHOLD = 3'd4,
    RDATA = 3'd5,
    TURN  = 3'd6
  } state_t;

  // Phases in which the master owns the AD bus.
  function automatic logic drives_ad(input state_t s);
    logic r;
    case (s)
      ADDR, AHOLD, WDATA, WHOLD: r = 1'b1;
      default:                   r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/fsmc_phase_timer.sv
// Loadable phase down-counter; done is suppressed while hold is asserted at the final count.
module fsmc_phase_timer
  import fsmc_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             hold,
  output logic             done
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: reload on phase entry, otherwise count down and park at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != {CNT_W{1'b0}}) begin
      cnt_d = cnt_q - CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == {CNT_W{1'b0}}) && !hold;

endmodule

// File: rtl/fsmc_bus_master.sv
// Request/response to multiplexed-bus cycle initiator with parameterised phase lengths.
// Optional NWAIT data-phase extension is enabled by defining FSMC_MASTER_NWAIT_EN.
module fsmc_bus_master
  import fsmc_pkg::*;
#(
  parameter int AD_W    = AD_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDSET  = 5,
  parameter int ADDHLD  = 4,
  parameter int DATAST  = 8,
  parameter int DATHLD  = 3,
  parameter int BUSTURN = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [AD_W-1:0]   req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy,
  output logic              NADV,
  output logic              NWE,
  output logic              NOE,
`ifdef FSMC_MASTER_NWAIT_EN
  input  logic              NWAIT,
`endif
  inout  wire  [AD_W-1:0]   AD
);

  localparam logic [CNT_W-1:0] ADDSET_M1  = CNT_W'(ADDSET - 1);
  localparam logic [CNT_W-1:0] ADDHLD_M1  = CNT_W'(ADDHLD - 1);
  localparam logic [CNT_W-1:0] DATAST_M1  = CNT_W'(DATAST - 1);
  localparam logic [CNT_W-1:0] DATHLD_M1  = CNT_W'(DATHLD - 1);
  localparam logic [CNT_W-1:0] BUSTURN_M1 = CNT_W'(BUSTURN - 1);

  state_t              state_q, state_d;
  logic                we_q, we_d;
  logic [AD_W-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                req_ready_q, req_ready_d;
  logic                busy_q, busy_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                nadv_q, nadv_d;
  logic                nwe_q, nwe_d;
  logic                noe_q, noe_d;
  logic                ad_oe_q, ad_oe_d;
  logic [AD_W-1:0]     ad_out_q, ad_out_d;
  logic                tmr_load;
  logic [CNT_W-1:0]    tmr_val;
  logic                tmr_hold;
  logic                tmr_done;

`ifdef FSMC_MASTER_NWAIT_EN
  assign tmr_hold = ((state_q == WDATA) || (state_q == RDATA)) && !NWAIT;
`else
  assign tmr_hold = 1'b0;
`endif

  fsmc_phase_timer u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .hold     (tmr_hold),
    .done     (tmr_done)
  );

  // Next state, request latch, response and strobe values for the coming cycle.
  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    tmr_load    = 1'b0;
    tmr_val     = {CNT_W{1'b0}};

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d = ADDR;
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
        end else begin
          state_d = IDLE;
        end
      end
      ADDR: begin
        if (tmr_done) state_d = AHOLD;
        else          state_d = ADDR;
      end
      AHOLD: begin
        if (tmr_done) state_d = we_q ? WDATA : RDATA;
        else          state_d = AHOLD;
      end
      WDATA: begin
        if (tmr_done) state_d = WHOLD;
        else          state_d = WDATA;
      end
      WHOLD: begin
        if (tmr_done) begin
          state_d     = TURN;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = {DATA_W{1'b0}};
        end else begin
          state_d = WHOLD;
        end
      end
      RDATA: begin
        // Sampled on the same edge that releases NOE.
        if (tmr_done) begin
          state_d     = TURN;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = AD[DATA_W-1:0];
        end else begin
          state_d = RDATA;
        end
      end
      TURN: begin
        if (tmr_done) state_d = IDLE;
        else          state_d = TURN;
      end
      default: state_d = IDLE;
    endcase

    if (state_d != state_q) begin
      tmr_load = 1'b1;
      case (state_d)
        ADDR:         tmr_val = ADDSET_M1;
        AHOLD:        tmr_val = ADDHLD_M1;
        WDATA, RDATA: tmr_val = DATAST_M1;
        WHOLD:        tmr_val = DATHLD_M1;
        TURN:         tmr_val = BUSTURN_M1;
        default:      tmr_val = {CNT_W{1'b0}};
      endcase
    end else begin
      tmr_load = 1'b0;
    end

    // Bus outputs are decoded from the next state so they change on the same edge as the state.
    req_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
    nadv_d      = (state_d != ADDR);
    nwe_d       = !((state_d == WDATA) || ((state_d == AHOLD) && we_d));
    noe_d       = (state_d != RDATA);
    ad_oe_d     = drives_ad(state_d);
    ad_out_d    = ((state_d == ADDR) || (state_d == AHOLD)) ? addr_d : AD_W'(wdata_d);
  end

  // State, request latch and registered bus/handshake outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      addr_q      <= {AD_W{1'b0}};
      wdata_q     <= {DATA_W{1'b0}};
      req_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= {DATA_W{1'b0}};
      nadv_q      <= 1'b1;
      nwe_q       <= 1'b1;
      noe_q       <= 1'b1;
      ad_oe_q     <= 1'b0;
      ad_out_q    <= {AD_W{1'b0}};
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      req_ready_q <= req_ready_d;
      busy_q      <= busy_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      nadv_q      <= nadv_d;
      nwe_q       <= nwe_d;
      noe_q       <= noe_d;
      ad_oe_q     <= ad_oe_d;
      ad_out_q    <= ad_out_d;
    end
  end

  assign AD        = ad_oe_q ? ad_out_q : {AD_W{1'bz}};
  assign req_ready = req_ready_q;
  assign busy      = busy_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign NADV      = nadv_q;
  assign NWE       = nwe_q;
  assign NOE       = noe_q;

endmodule

// File: tb/tb_fsmc_bus_master.sv
// Self-checking bench for fsmc_bus_master: vector table, random accesses against a timing model,
// and hand sequences for back-to-back, reset abort, request wiggling and (optionally) NWAIT.
module tb_fsmc_bus_master;

  localparam int ADDSET  = 5;
  localparam int ADDHLD  = 4;
  localparam int DATAST  = 8;
  localparam int DATHLD  = 3;
  localparam int BUSTURN = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [17:0] req_addr = 18'h0;
  logic [15:0] req_wdata = 16'h0;
  logic        nwait = 1'b1;
  logic [15:0] slave_val = 16'h0;
  wire         req_ready, rsp_valid, busy, nadv, nwe, noe;
  wire  [15:0] rsp_rdata;
  wire  [17:0] ad;

  int n_cmp = 0;
  int n_bad = 0;

  // Slave model: drives the read value only while the strobe is low.
  assign ad = (noe == 1'b0) ? {2'b00, slave_val} : 18'bz;

  fsmc_bus_master dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .busy      (busy),
    .NADV      (nadv),
    .NWE       (nwe),
    .NOE       (noe),
`ifdef FSMC_MASTER_NWAIT_EN
    .NWAIT     (nwait),
`endif
    .AD        (ad)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          nadv_low, addr_bad, nwe_low, noe_low, both_low, data_cyc, lat, rsp_cnt, nadv_falls;
    logic [15:0] rdata, rdata_hold;
  } meas_t;

  typedef struct {
    logic        we;
    logic [17:0] addr;
    logic [15:0] wd, sd;
    int          nadv, nwe, noe, dat, lat;
    logic [15:0] rdata;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: actual %0d (0x%0h) required %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Reference timing: each phase lasts its parameter count, NWAIT stretches the data phase.
  function automatic void model(input logic we, input logic [15:0] sd, input int nw,
                                output int e_nwe, output int e_noe, output int e_dat,
                                output int e_lat, output logic [15:0] e_rd);
    e_nwe = we ? ADDHLD + DATAST : 0;
    e_noe = we ? 0 : DATAST + nw;
    e_dat = we ? DATAST + DATHLD : 0;
    e_lat = ADDSET + ADDHLD + DATAST + BUSTURN + (we ? DATHLD : nw);
    e_rd  = we ? 16'h0000 : sd;
  endfunction

  task automatic run_access(input logic we, input logic [17:0] addr, input logic [15:0] wd,
                            input logic [15:0] sd, input int nw, input bit wiggle, output meas_t m);
    logic prev_nadv;
    m = '{default: 0};
    m.lat = -1;
    @(negedge clk);
    for (int i = 0; i < 50 && !req_ready; i++) @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; slave_val = sd;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_we = ~we; req_addr = ~addr; req_wdata = ~wd;
    prev_nadv = 1'b1;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (!nadv) begin
        m.nadv_low++;
        if (ad !== addr) m.addr_bad++;
      end
      if (prev_nadv && !nadv) m.nadv_falls++;
      prev_nadv = nadv;
      if (!nwe) m.nwe_low++;
      if (!noe) m.noe_low++;
      if (!nwe && !noe) m.both_low++;
      if (we && busy && (ad === {2'b00, wd})) m.data_cyc++;
      if (rsp_valid) begin
        m.rsp_cnt++;
        m.rdata = rsp_rdata;
      end
      if (req_ready) begin
        m.lat = k;
        req_valid = 1'b0;
        break;
      end
      if (wiggle) begin
        req_valid = 1'($urandom_range(0, 1));
        req_addr  = 18'($urandom);
      end
      nwait = !((nw > 0) && (m.noe_low >= DATAST) && (m.noe_low < DATAST + nw));
      slave_val = nwait ? sd : 16'hDEAD;
    end
    req_valid = 1'b0;
    nwait = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (rsp_valid) m.rsp_cnt++;
    end
    m.rdata_hold = rsp_rdata;
  endtask

  task automatic check_all(input string tag, input meas_t m, input int e_nadv, input int e_nwe,
                           input int e_noe, input int e_dat, input int e_lat, input logic [15:0] e_rd);
    chk({tag, ".nadv_low"},   m.nadv_low, e_nadv);
    chk({tag, ".addr_hold"},  m.addr_bad, 0);
    chk({tag, ".nwe_low"},    m.nwe_low, e_nwe);
    chk({tag, ".noe_low"},    m.noe_low, e_noe);
    chk({tag, ".strobe_mux"}, m.both_low, 0);
    chk({tag, ".data_cyc"},   m.data_cyc, e_dat);
    chk({tag, ".latency"},    m.lat, e_lat);
    chk({tag, ".rsp_once"},   m.rsp_cnt, 1);
    chk({tag, ".rdata"},      int'(m.rdata), int'(e_rd));
    chk({tag, ".rdata_held"}, int'(m.rdata_hold), int'(e_rd));
    chk({tag, ".one_access"}, m.nadv_falls, 1);
  endtask

  initial begin
    vec_t        vt[4];
    meas_t       m;
    int          e_nwe, e_noe, e_dat, e_lat;
    logic [15:0] e_rd;
    logic        r_we;
    logic [17:0] r_addr;
    logic [15:0] r_wd, r_sd;
    int          k_idle, last_noe, second_adv, rsps;

    vt[0] = '{1'b1, 18'h10000, 16'h0F0F, 16'h0000, 5, 12, 0, 11, 22, 16'h0000};
    vt[1] = '{1'b0, 18'h10000, 16'h0000, 16'hA5C3, 5, 0, 8, 0, 19, 16'hA5C3};
    vt[2] = '{1'b0, 18'h3FFFF, 16'h1111, 16'h0001, 5, 0, 8, 0, 19, 16'h0001};
    vt[3] = '{1'b1, 18'h2ABCD, 16'hFFFF, 16'h0000, 5, 12, 0, 11, 22, 16'h0000};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst.nadv", nadv, 1);
    chk("rst.nwe", nwe, 1);
    chk("rst.noe", noe, 1);
    chk("rst.ready", req_ready, 1);
    chk("rst.busy", busy, 0);
    chk("rst.rsp_valid", rsp_valid, 0);
    chk("rst.rsp_rdata", int'(rsp_rdata), 0);
    reset = 1'b0;

    for (int i = 0; i < 4; i++) begin
      run_access(vt[i].we, vt[i].addr, vt[i].wd, vt[i].sd, 0, 1'b0, m);
      check_all($sformatf("vec%0d", i), m, vt[i].nadv, vt[i].nwe, vt[i].noe, vt[i].dat,
                vt[i].lat, vt[i].rdata);
    end

    for (int i = 0; i < 10; i++) begin
      r_we   = 1'($urandom_range(0, 1));
      r_addr = {1'b1, 17'($urandom)};
      r_wd   = 16'($urandom_range(1, 65535));
      r_sd   = 16'($urandom);
      run_access(r_we, r_addr, r_wd, r_sd, 0, 1'b0, m);
      model(r_we, r_sd, 0, e_nwe, e_noe, e_dat, e_lat, e_rd);
      check_all($sformatf("rnd%0d", i), m, ADDSET, e_nwe, e_noe, e_dat, e_lat, e_rd);
    end

    run_access(1'b0, 18'h10000, 16'h0000, 16'h3C3C, 0, 1'b1, m);
    model(1'b0, 16'h3C3C, 0, e_nwe, e_noe, e_dat, e_lat, e_rd);
    check_all("wiggle", m, ADDSET, e_nwe, e_noe, e_dat, e_lat, e_rd);

    // Back-to-back reads with req_valid held high.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 18'h10000; slave_val = 16'h5A5A;
    @(posedge clk);
    #1;
    k_idle = -1; last_noe = -1; second_adv = -1; rsps = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (!noe && k_idle < 0) last_noe = k;
      if (rsp_valid) rsps++;
      if (!busy && k_idle < 0) begin
        k_idle = k;
      end else if (k_idle >= 0 && second_adv < 0 && !nadv) begin
        second_adv = k;
        req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    chk("b2b.first_idle", k_idle, ADDSET + ADDHLD + DATAST + BUSTURN);
    chk("b2b.accept_next", second_adv - k_idle, 1);
    chk("b2b.gap", second_adv - last_noe - 1, BUSTURN + 1);
    chk("b2b.rsp", rsps, 2);
    chk("b2b.rdata", int'(rsp_rdata), 16'h5A5A);

    // Reset during the third write-data cycle aborts the access.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 18'h10000; req_wdata = 16'h0F0F;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    rsps = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (rsp_valid) rsps++;
    end
    chk("abort.in_wdata", nwe, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("abort.nwe", nwe, 1);
    chk("abort.nadv", nadv, 1);
    chk("abort.noe", noe, 1);
    chk("abort.ready", req_ready, 1);
    chk("abort.busy", busy, 0);
    chk("abort.ad_released", int'(ad === 18'h00F0F), 0);
    reset = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (rsp_valid) rsps++;
    end
    chk("abort.no_rsp", rsps, 0);

`ifdef FSMC_MASTER_NWAIT_EN
    run_access(1'b0, 18'h10000, 16'h0000, 16'h1234, 6, 1'b0, m);
    model(1'b0, 16'h1234, 6, e_nwe, e_noe, e_dat, e_lat, e_rd);
    check_all("nwait", m, ADDSET, e_nwe, e_noe, e_dat, e_lat, e_rd);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
